control_unit: RTL
=================

# control_unit

Moore-style control FSM that sequences the ProjectB processor's fetch/decode/execute loop. It sits directly upstream of the program counter and drives its `up`/`clear` inputs. It also loads the instruction register, decodes the registered 16-bit instruction, and drives the data-memory, register-file and ALU control lines. Every instruction returns to FETCH, except HALT, which parks the machine until reset.

## Interface
Parameters:
- None; all widths are fixed by the ProjectB datapath.

Ports:
- `clk`  in  1  system clock; all state changes occur on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ir`  in  16  instruction register contents; `ir[15:12]` is the opcode.
- `pc_up`  out  1  PC increment enable.
- `pc_clr`  out  1  PC synchronous clear.
- `ir_ld`  out  1  IR load enable.
- `d_addr`  out  8  data-memory address.
- `d_wr`  out  1  data-memory write enable.
- `rf_s`  out  1  register-file write-data mux select: 1 = data memory, 0 = ALU.
- `rf_w_addr`  out  4  register-file write address.
- `rf_w_en`  out  1  register-file write enable.
- `rf_ra_addr`  out  4  register-file read port A address.
- `rf_rb_addr`  out  4  register-file read port B address.
- `alu_s0`  out  3  ALU function: 000 = pass A, 001 = add, 010 = subtract.
- `state_out`  out  4  current state encoding, for debug and display.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  undefined opcode trapped; see Configuration.

## Operation
- Opcodes:
  - NOOP = 0000
  - STORE = 0001
  - LOAD = 0010
  - ADD = 0011
  - SUB = 0100
  - HALT = 0101
  - 0110–1111 are undefined.
- Field use by instruction:
  - LOAD: `d_addr = ir[11:4]`, `rf_w_addr = ir[3:0]`.
  - STORE: `d_addr = ir[11:4]`, `rf_ra_addr = ir[3:0]`.
  - ADD/SUB: `rf_ra_addr = ir[11:8]`, `rf_rb_addr = ir[7:4]`, `rf_w_addr = ir[3:0]`.
- State encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Transitions:
  - INIT → FETCH.
  - FETCH → DECODE.
  - DECODE → state selected by opcode.
  - NOOP, LOAD_B, STORE, ADD, SUB → FETCH.
  - LOAD_A → LOAD_B.
  - HALT → HALT.
- Outputs per state (every signal not listed is 0):
  - INIT: `pc_clr=1`.
  - FETCH: `ir_ld=1`, `pc_up=1`.
  - LOAD_A: `d_addr` driven, `rf_s=1`, `rf_w_addr` driven.
  - LOAD_B: same as LOAD_A, plus `rf_w_en=1`.
  - STORE: `d_addr` driven, `rf_ra_addr` driven, `d_wr=1`.
  - ADD: `rf_ra_addr`, `rf_rb_addr`, `rf_w_addr` driven; `alu_s0=001`; `rf_w_en=1`; `rf_s=0`.
  - SUB: same as ADD, with `alu_s0=010`.
  - HALT: `halted=1`.
- Outputs are decoded from the current state and `ir` only; there are no Mealy paths from other inputs.
- Address outputs take `ir` fields in their active states and are 0 elsewhere.

## Timing
- Reset: `reset_n` low forces INIT immediately, without waiting for a clock edge. All outputs then show their INIT values: `pc_clr=1`, everything else 0, `state_out=0`.
- Reset asserted mid-operation, including during STORE or LOAD_B, deasserts `d_wr` and `rf_w_en` combinationally.
- The first rising edge after `reset_n` rises moves INIT → FETCH. The PC therefore reads 0 at the first FETCH.
- FETCH edge: IR loads `mem[pc]` and the PC increments on the same edge. `ir` is valid throughout DECODE.
- Cycles per instruction:
  - NOOP, STORE, ADD, SUB: 3 (FETCH, DECODE, execute).
  - LOAD: 4. The data memory read is synchronous, so the address is presented in LOAD_A and the data is written in LOAD_B.
- The 7-bit PC wraps from 127 to 0 without any action from this block. Fetching continues normally across the wrap.
- HALT is left only by reset. In HALT, `pc_up` and `ir_ld` stay 0, so the PC and IR hold their values.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined:
  - An undefined opcode in DECODE goes to HALT.
  - `illegal` rises with the transition and stays 1 until reset.
- `CU_ILLEGAL_TRAP_EN` undefined:
  - An undefined opcode goes to NOOP and execution continues.
  - `illegal` is tied to 0.

## Test plan
- Reset release with `ir=0000_0000_0000_0000` → `state_out` sequence 0,1,2,3,1; `pc_up` high exactly in cycle 2; `pc_clr` high only in cycle 1.
- LOAD `ir=0x2_1B_5` → LOAD_A shows `d_addr=0x1B`, `rf_s=1`, `rf_w_en=0`; LOAD_B shows `rf_w_en=1`, `rf_w_addr=5`; returns to FETCH on the next edge.
- STORE `ir=0x1_40_3` → exactly one cycle of `d_wr=1`, with `d_addr=0x40` and `rf_ra_addr=3`.
- ADD `ir=0x3_2_7_9` → `rf_ra_addr=2`, `rf_rb_addr=7`, `rf_w_addr=9`, `alu_s0=001`, `rf_w_en=1` for one cycle. SUB `ir=0x4_2_7_9` → identical, with `alu_s0=010`.
- HALT `ir=0x5000` → `halted=1`, and `pc_up`/`ir_ld` stay 0 for 20 cycles. Then pull `reset_n` low mid-cycle → `state_out=0` before the next edge.
- `ir=0xF000` → with the macro: HALT and `illegal=1`. Without the macro: NOOP then FETCH, and `illegal=0`.

Source files
------------

// File: rtl/control_unit_if.sv
// Bundle of the instruction-register input and all datapath control lines of the ProjectB control unit.
// master = control unit side, slave = datapath side.
interface control_unit_if;
    logic [15:0] ir;
    logic        pc_up;
    logic        pc_clr;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [2:0]  alu_s0;
    logic [3:0]  state_out;
    logic        halted;
    logic        illegal;

    modport master (
        input  ir,
        output pc_up, pc_clr, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s0, state_out, halted, illegal
    );

    modport slave (
        output ir,
        input  pc_up, pc_clr, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s0, state_out, halted, illegal
    );
endinterface

// File: rtl/control_unit.sv
// ProjectB fetch/decode/execute control FSM. Define CU_ILLEGAL_TRAP_EN to trap undefined
// opcodes into HALT with a sticky illegal flag; otherwise they execute as NOOP.
module control_unit (
    input  logic          clk,
    input  logic          reset_n,
    control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    state_e      state_q, state_d;
    logic        pc_up_q, pc_up_d;
    logic        pc_clr_q, pc_clr_d;
    logic        ir_ld_q, ir_ld_d;
    logic [7:0]  d_addr_q, d_addr_d;
    logic        d_wr_q, d_wr_d;
    logic        rf_s_q, rf_s_d;
    logic [3:0]  rf_w_addr_q, rf_w_addr_d;
    logic        rf_w_en_q, rf_w_en_d;
    logic [3:0]  rf_ra_addr_q, rf_ra_addr_d;
    logic [3:0]  rf_rb_addr_q, rf_rb_addr_d;
    logic [2:0]  alu_s0_q, alu_s0_d;
    logic        halted_q, halted_d;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        illegal_q, illegal_d;
`endif

    // Next-state selection, including opcode dispatch out of DECODE
    always_comb begin
        state_d = state_q;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.ir[15:12])
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_NOOP;
`endif
                    end
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Outputs are precomputed for the state being entered so they come straight from flops;
    // ir is stable from the FETCH edge onward, so this equals a decode of the current state.
    always_comb begin
        pc_up_d      = 1'b0;
        pc_clr_d     = 1'b0;
        ir_ld_d      = 1'b0;
        d_addr_d     = 8'h00;
        d_wr_d       = 1'b0;
        rf_s_d       = 1'b0;
        rf_w_addr_d  = 4'h0;
        rf_w_en_d    = 1'b0;
        rf_ra_addr_d = 4'h0;
        rf_rb_addr_d = 4'h0;
        alu_s0_d     = 3'b000;
        halted_d     = 1'b0;
        case (state_d)
            S_INIT:  pc_clr_d = 1'b1;
            S_FETCH: begin
                ir_ld_d = 1'b1;
                pc_up_d = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                d_addr_d    = bus.ir[11:4];
                rf_s_d      = 1'b1;
                rf_w_addr_d = bus.ir[3:0];
                rf_w_en_d   = (state_d == S_LOAD_B) ? 1'b1 : 1'b0;
            end
            S_STORE: begin
                d_addr_d     = bus.ir[11:4];
                rf_ra_addr_d = bus.ir[3:0];
                d_wr_d       = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr_d = bus.ir[11:8];
                rf_rb_addr_d = bus.ir[7:4];
                rf_w_addr_d  = bus.ir[3:0];
                rf_w_en_d    = 1'b1;
                alu_s0_d     = (state_d == S_SUB) ? 3'b010 : 3'b001;
            end
            S_HALT:  halted_d = 1'b1;
            default: pc_clr_d = 1'b0;
        endcase
    end

    // State and output registers; async reset lands directly on the INIT output pattern
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT;
            pc_up_q      <= 1'b0;
            pc_clr_q     <= 1'b1;
            ir_ld_q      <= 1'b0;
            d_addr_q     <= 8'h00;
            d_wr_q       <= 1'b0;
            rf_s_q       <= 1'b0;
            rf_w_addr_q  <= 4'h0;
            rf_w_en_q    <= 1'b0;
            rf_ra_addr_q <= 4'h0;
            rf_rb_addr_q <= 4'h0;
            alu_s0_q     <= 3'b000;
            halted_q     <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_up_q      <= pc_up_d;
            pc_clr_q     <= pc_clr_d;
            ir_ld_q      <= ir_ld_d;
            d_addr_q     <= d_addr_d;
            d_wr_q       <= d_wr_d;
            rf_s_q       <= rf_s_d;
            rf_w_addr_q  <= rf_w_addr_d;
            rf_w_en_q    <= rf_w_en_d;
            rf_ra_addr_q <= rf_ra_addr_d;
            rf_rb_addr_q <= rf_rb_addr_d;
            alu_s0_q     <= alu_s0_d;
            halted_q     <= halted_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q    <= illegal_d;
`endif
        end
    end

    assign bus.pc_up      = pc_up_q;
    assign bus.pc_clr     = pc_clr_q;
    assign bus.ir_ld      = ir_ld_q;
    assign bus.d_addr     = d_addr_q;
    assign bus.d_wr       = d_wr_q;
    assign bus.rf_s       = rf_s_q;
    assign bus.rf_w_addr  = rf_w_addr_q;
    assign bus.rf_w_en    = rf_w_en_q;
    assign bus.rf_ra_addr = rf_ra_addr_q;
    assign bus.rf_rb_addr = rf_rb_addr_q;
    assign bus.alu_s0     = alu_s0_q;
    assign bus.state_out  = state_q;
    assign bus.halted     = halted_q;
`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.illegal    = illegal_q;
`else
    assign bus.illegal    = 1'b0;
`endif
endmodule
